// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM port between fetch and data requesters
// Partial-word data writes become a read-modify-write: a read phase, then one write-back cycle.
module ram_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [3:0]        r1_be,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic ST_ARB    = 1'b0;
  localparam logic ST_RMW_WB = 1'b1;

  logic              state_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [3:0]        rmw_be_q;
  logic [31:0]       rmw_wdata_q;

  logic              gnt0_c;
  logic              gnt1_c;
  logic              full_wr_c;
  logic              part_wr_c;
  logic [31:0]       merged_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [31:0]       ram_din_c;
  logic              ram_we_c;

  // last_q = 1 means r1 was granted last, so r0 wins a tie.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rstn && state_q == ST_ARB) begin
      if (r0_req && r1_req) begin
        gnt0_c = last_q;
        gnt1_c = !last_q;
      end else begin
        gnt0_c = r0_req;
        gnt1_c = r1_req;
      end
    end
  end

  assign full_wr_c = gnt1_c && r1_we && (r1_be == 4'hF);
  assign part_wr_c = gnt1_c && r1_we && (r1_be != 4'h0) && (r1_be != 4'hF);

  always_comb begin
    merged_c = ram_dout;
    for (int i = 0; i < 4; i++) begin
      if (rmw_be_q[i]) begin
        merged_c[8*i +: 8] = rmw_wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    ram_addr_c = addr_q;
    ram_din_c  = din_q;
    ram_we_c   = 1'b0;
    if (!rstn) begin
      ram_addr_c = '0;
      ram_din_c  = '0;
    end else if (state_q == ST_RMW_WB) begin
      ram_addr_c = rmw_addr_q;
      ram_din_c  = merged_c;
      ram_we_c   = 1'b1;
    end else if (gnt0_c) begin
      ram_addr_c = r0_addr;
    end else if (gnt1_c) begin
      ram_addr_c = r1_addr;
      if (full_wr_c) begin
        ram_din_c = r1_wdata;
        ram_we_c  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ARB;
      last_q      <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= 4'h0;
      rmw_wdata_q <= '0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
    end else begin
      addr_q    <= ram_addr_c;
      din_q     <= ram_din_c;
      r0_rvalid <= gnt0_c;
      // A partial write acknowledges from the write-back cycle, not the read phase.
      r1_rvalid <= (gnt1_c && !part_wr_c) || (state_q == ST_RMW_WB);
      if (gnt0_c) begin
        last_q <= 1'b0;
      end else if (gnt1_c) begin
        last_q <= 1'b1;
      end
      if (part_wr_c) begin
        state_q     <= ST_RMW_WB;
        rmw_addr_q  <= r1_addr;
        rmw_be_q    <= r1_be;
        rmw_wdata_q <= r1_wdata;
      end else begin
        state_q <= ST_ARB;
      end
    end
  end

  assign r0_gnt   = gnt0_c;
  assign r1_gnt   = gnt1_c;
  assign ram_we   = ram_we_c;
  assign ram_addr = ram_addr_c;
  assign ram_din  = ram_din_c;
  assign r0_rdata = ram_dout;
  assign r1_rdata = ram_dout;

endmodule
